dt_phase_sequencer: RTL
=======================

// Module: dt_phase_sequencer
// PURPOSE
// - Sequences the three distance-transform phase engines (0=init, 1=forward pass, 2=backward pass) one at a time.
// - Owns the single sti ROM port and the single res RAM port, granting them only to the active phase.
// - Adds a start handshake, a per-phase watchdog, and a cycle counter for the last completed phase.
// - Sits between the phase engines and the memory interface in the DT top level.
// PARAMETERS
// - TO_W     20      width of the watchdog/cycle counter
// - TIMEOUT  100000  max cycles a phase may run before error (must be >=2 and <2**TO_W)
// PORTS
// - clk           in   1      clock, all logic on posedge
// - rst           in   1      synchronous, active-high reset
// - start         in   1      run request, honoured in IDLE, DONE, ERR only
// - ph_start      out  3      one-hot, one-cycle start pulse to phase k
// - ph_done       in   3      phase k finished (level or pulse)
// - init_sti_rd   in   1      sti read request from phase 0
// - init_sti_addr in   10     sti address from phase 0
// - ph_res_wr     in   3      res write request, bit k = phase k
// - ph_res_rd     in   3      res read request, bit k = phase k
// - ph_res_addr   in   42     packed, phase k at [14k+13:14k]
// - ph_res_do     in   24     packed, phase k at [8k+7:8k]
// - sti_rd        out  1      to sti ROM
// - sti_addr      out  10     to sti ROM
// - res_wr/res_rd out  1      to res RAM
// - res_addr      out  14     to res RAM
// - res_do        out  8      to res RAM
// - busy          out  1      high in RUN0..RUN2
// - done          out  1      high in DONE
// - err           out  1      high in ERR
// - err_phase     out  2      phase that timed out (valid while err)
// - phase_cycles  out  TO_W   cycles taken by last completed phase
// BEHAVIOUR
// - States: IDLE, RUN0, RUN1, RUN2, DONE, ERR; encoded state is a register.
// - Reset: state=IDLE, timer=0, ph_start=0, err_phase=0, phase_cycles=0; all memory outputs 0; busy=done=err=0.
// - Reset mid-operation: same values next cycle; no further ph_start; engines are not notified.
// - IDLE/DONE/ERR + start -> RUN0; ph_start=3'b001 in the first RUN0 cycle; timer cleared to 0.
// - On entry to RUNk, ph_start[k]=1 for exactly the first cycle; timer=0 that cycle and +1 per cycle.
// - In RUNk, ph_done[k]=1 -> phase_cycles<=timer+1, then RUN0->RUN1, RUN1->RUN2, RUN2->DONE.
// - ph_done bits for non-active phases are ignored in every state.
// - ph_done[k] in the ph_start[k] cycle counts: phase_cycles=1.
// - Watchdog: in RUNk, timer==TIMEOUT-1 and ph_done[k]=0 -> ERR, err_phase<=k.
// - ph_done[k] in the same cycle as timer==TIMEOUT-1: done wins, no error.
// - start in RUNk is ignored. start in DONE or ERR restarts at RUN0; err_phase holds until then.
// - Port mux is combinational from the state register:
// - In RUN0, sti_rd/sti_addr follow phase 0. In all other states both are 0.
// - In RUNk, res_wr/rd/addr/do follow phase k. In all other states all are 0.
// - The cycle that ph_done[k] is sampled still forwards phase k's access.
// - Inactive-phase requests are dropped silently; they are not queued.
// - Timer saturates at TIMEOUT-1. phase_cycles updates only on a completion.
// TESTING
// - Reset, then start; engines assert done after 5/7/3 cycles -> ph_start pulses 001,010,100; done=1; phase_cycles=3.
// - Phase 1 drives addr 14'h1234, wr=1; phase 0 drives 14'h0FFF -> res_addr=14'h1234 only while RUN1; 0 in DONE.
// - TIMEOUT=8, phase 1 never done -> ERR exactly 8 cycles after ph_start[1]; err_phase=1; all memory outputs 0.
// - TIMEOUT=8, ph_done[2] at timer=7 -> DONE, err=0, phase_cycles=8.
// - ph_done[2] pulsed during RUN0 -> ignored, still RUN0; start pulsed in RUN1 -> no restart.
// - rst asserted mid-RUN1 -> next cycle IDLE, outputs 0; a new start gives ph_start=001.

Source files
------------

// File: rtl/dt_phase_sequencer_if.sv
// dt_phase_sequencer_if: phase-engine handshake and sti/res memory port bundle.
// The sequencer is the master; engines and memories sit on the slave side.
interface dt_phase_sequencer_if #(
    parameter int TO_W = 20
);
    logic            start;
    logic [2:0]      ph_start;
    logic [2:0]      ph_done;
    logic            init_sti_rd;
    logic [9:0]      init_sti_addr;
    logic [2:0]      ph_res_wr;
    logic [2:0]      ph_res_rd;
    logic [41:0]     ph_res_addr;
    logic [23:0]     ph_res_do;
    logic            sti_rd;
    logic [9:0]      sti_addr;
    logic            res_wr;
    logic            res_rd;
    logic [13:0]     res_addr;
    logic [7:0]      res_do;
    logic            busy;
    logic            done;
    logic            err;
    logic [1:0]      err_phase;
    logic [TO_W-1:0] phase_cycles;

    modport master (
        input  start, ph_done, init_sti_rd, init_sti_addr,
               ph_res_wr, ph_res_rd, ph_res_addr, ph_res_do,
        output ph_start, sti_rd, sti_addr, res_wr, res_rd, res_addr, res_do,
               busy, done, err, err_phase, phase_cycles
    );

    modport slave (
        output start, ph_done, init_sti_rd, init_sti_addr,
               ph_res_wr, ph_res_rd, ph_res_addr, ph_res_do,
        input  ph_start, sti_rd, sti_addr, res_wr, res_rd, res_addr, res_do,
               busy, done, err, err_phase, phase_cycles
    );
endinterface

// File: rtl/dt_phase_sequencer.sv
// dt_phase_sequencer: runs the init/forward/backward DT phases in turn with a
// per-phase watchdog, and grants the sti ROM and res RAM ports to the active phase.
module dt_phase_sequencer #(
    parameter int TO_W    = 20,
    parameter int TIMEOUT = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    dt_phase_sequencer_if.master  bus
);
    typedef enum logic [2:0] {IDLE, RUN0, RUN1, RUN2, DONE, ERR} state_t;

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic [TO_W-1:0] cycles_q, cycles_d;
    logic [1:0]      err_phase_q, err_phase_d;
    logic [1:0]      k;
    logic            run;
    logic            k_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            cycles_q    <= '0;
            err_phase_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cycles_q    <= cycles_d;
            err_phase_q <= err_phase_d;
        end
    end

    // Completion is checked before the watchdog so a done on the last allowed cycle wins.
    always_comb begin
        run         = state_q inside {RUN0, RUN1, RUN2};
        k           = state_q == RUN1 ? 2'd1 : state_q == RUN2 ? 2'd2 : 2'd0;
        k_done      = run && bus.ph_done[k];
        state_d     = state_q;
        timer_d     = timer_q;
        cycles_d    = cycles_q;
        err_phase_d = err_phase_q;
        if (run) begin
            if (k_done) begin
                state_d  = state_q == RUN0 ? RUN1 : state_q == RUN1 ? RUN2 : DONE;
                cycles_d = timer_q + 1'b1;
                timer_d  = '0;
            end else if (timer_q == LIMIT) begin
                state_d     = ERR;
                err_phase_d = k;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end else if (bus.start) begin
            state_d = RUN0;
            timer_d = '0;
        end
    end

    // Timer is zero only in the first cycle of a phase, which marks the start pulse.
    assign bus.ph_start     = (run && timer_q == '0) ? 3'b001 << k : 3'b000;
    assign bus.sti_rd       = state_q == RUN0 && bus.init_sti_rd;
    assign bus.sti_addr     = state_q == RUN0 ? bus.init_sti_addr : '0;
    assign bus.res_wr       = run && bus.ph_res_wr[k];
    assign bus.res_rd       = run && bus.ph_res_rd[k];
    assign bus.res_addr     = run ? bus.ph_res_addr[14*k +: 14] : '0;
    assign bus.res_do       = run ? bus.ph_res_do[8*k +: 8] : '0;
    assign bus.busy         = run;
    assign bus.done         = state_q == DONE;
    assign bus.err          = state_q == ERR;
    assign bus.err_phase    = err_phase_q;
    assign bus.phase_cycles = cycles_q;
endmodule
